// File: rtl/modn_pkg.sv
// Shared definitions for the MOD-N sweep sequencer: state encoding and direction constants.
package modn_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_UP   = 2'd1;
    localparam logic [1:0] ST_DOWN = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_UP   = ST_UP,
        S_DOWN = ST_DOWN,
        S_DONE = ST_DONE
    } state_e;

endpackage

// File: rtl/modn_updown_core.sv
// Up/down counter modulo N with enable and synchronous clear; wraps in both directions.
module modn_updown_core #(
    parameter int N = 10,
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         up,
    input  logic         clr,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] CNT_MAX = W'(N - 1);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            if (up) begin
                count_d = (count_q == CNT_MAX) ? '0 : count_q + W'(1);
            end else begin
                count_d = (count_q == '0) ? CNT_MAX : count_q - W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/modn_sweep_ctrl.sv
// Triangle-sweep sequencer: drives a MOD-N counter 0..N-1..0 for a programmed number of sweeps,
// holding each value for dwell+1 cycles, with start/busy/done handshake and abort.
module modn_sweep_ctrl
    import modn_pkg::*;
#(
    parameter int N  = 10,
    parameter int W  = 4,
    parameter int SW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          abort,
    input  logic [SW-1:0] sweeps,
    input  logic [3:0]    dwell,
    output logic          busy,
    output logic          done,
    output logic          updown,
    output logic [W-1:0]  count,
    output logic [SW-1:0] sweep_cnt
);

    localparam logic [W-1:0] CNT_PENULT = W'(N - 2);
    localparam logic [W-1:0] CNT_ONE    = W'(1);

    state_e        state_q;
    logic          busy_q;
    logic          done_q;
    logic          updown_q;
    logic [3:0]    dwell_cnt_q;
    logic [3:0]    dwell_cnt_d;
    logic [3:0]    dwell_q;
    logic [SW-1:0] sweeps_q;
    logic [SW-1:0] sweep_cnt_q;
    logic [SW-1:0] sweep_cnt_d;

    logic running;
    logic accept;
    logic step;
    logic last_up;
    logic last_down;
    logic core_up;

    assign running     = (state_q == S_UP) || (state_q == S_DOWN);
    assign accept      = (state_q == S_IDLE) && start && !abort;
    // Abort takes priority over a step landing on the same edge, so count freezes where it was.
    assign step        = running && !abort && (dwell_cnt_q == dwell_q);
    assign dwell_cnt_d = step ? 4'd0 : dwell_cnt_q + 4'd1;
    assign last_up     = step && (state_q == S_UP)   && (count == CNT_PENULT);
    assign last_down   = step && (state_q == S_DOWN) && (count == CNT_ONE);
    assign sweep_cnt_d = sweep_cnt_q + SW'(1);
    assign core_up     = (state_q == S_UP);

    modn_updown_core #(
        .N (N),
        .W (W)
    ) u_core (
        .clk   (clk),
        .reset (reset),
        .en    (step),
        .up    (core_up),
        .clr   (accept),
        .count (count)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            updown_q    <= DIR_UP;
            dwell_cnt_q <= 4'd0;
            dwell_q     <= 4'd0;
            sweeps_q    <= '0;
            sweep_cnt_q <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (accept) begin
                        sweeps_q    <= sweeps;
                        dwell_q     <= dwell;
                        sweep_cnt_q <= '0;
                        dwell_cnt_q <= 4'd0;
                        updown_q    <= DIR_UP;
                        busy_q      <= 1'b1;
                        if (sweeps == '0) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_UP;
                        end
                    end
                end
                S_UP: begin
                    if (abort) begin
                        state_q  <= S_IDLE;
                        busy_q   <= 1'b0;
                        updown_q <= DIR_UP;
                    end else begin
                        dwell_cnt_q <= dwell_cnt_d;
                        if (last_up) begin
                            state_q  <= S_DOWN;
                            updown_q <= DIR_DOWN;
                        end
                    end
                end
                S_DOWN: begin
                    if (abort) begin
                        state_q  <= S_IDLE;
                        busy_q   <= 1'b0;
                        updown_q <= DIR_UP;
                    end else begin
                        dwell_cnt_q <= dwell_cnt_d;
                        if (last_down) begin
                            sweep_cnt_q <= sweep_cnt_d;
                            updown_q    <= DIR_UP;
                            if (sweep_cnt_d == sweeps_q) begin
                                state_q <= S_DONE;
                                done_q  <= 1'b1;
                            end else begin
                                state_q <= S_UP;
                            end
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign updown    = updown_q;
    assign sweep_cnt = sweep_cnt_q;

endmodule

// File: tb/tb_modn_sweep_ctrl.sv
// Bench for modn_sweep_ctrl: two instances (N=10, N=4) share stimulus; a trajectory model
// predicts every output cycle, plus hand-computed expectations for the directed scenarios.
module tb_modn_sweep_ctrl;

    localparam int NA = 10;
    localparam int NB = 4;
    localparam int W  = 4;
    localparam int SW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [SW-1:0] sweeps = '0;
    logic [3:0]    dwell = 4'd0;

    logic          busy_a, done_a, updown_a;
    logic [W-1:0]  count_a;
    logic [SW-1:0] swc_a;
    logic          busy_b, done_b, updown_b;
    logic [W-1:0]  count_b;
    logic [SW-1:0] swc_b;

    always #5 clk = ~clk;

    modn_sweep_ctrl #(.N(NA), .W(W), .SW(SW)) dut_a (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .sweeps(sweeps), .dwell(dwell),
        .busy(busy_a), .done(done_a), .updown(updown_a),
        .count(count_a), .sweep_cnt(swc_a)
    );

    modn_sweep_ctrl #(.N(NB), .W(W), .SW(SW)) dut_b (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .sweeps(sweeps), .dwell(dwell),
        .busy(busy_b), .done(done_b), .updown(updown_b),
        .count(count_b), .sweep_cnt(swc_b)
    );

    typedef struct packed {
        logic [3:0] count;
        logic       updown;
        logic       busy;
        logic       done;
        logic [7:0] sw;
    } tup_t;

    tup_t cur_m [2];
    tup_t q_m [2][$];
    bit   mvalid = 1'b0;
    int   checks = 0;
    int   failures = 0;

    function automatic tup_t mk(input int c, input bit ud, input bit b, input bit d, input int s);
        tup_t t;
        t.count  = 4'(c);
        t.updown = ud;
        t.busy   = b;
        t.done   = d;
        t.sw     = 8'(s);
        return t;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s t=%0t got=%0d want=%0d", nm, $time, act, exp);
        end
    endtask

    // Whole-run trajectory: one tuple per edge after the accepting edge.
    task automatic build_run(input int k, input int n, input int nsw, input int dw);
        tup_t held;
        tup_t nxt;
        int   v;
        q_m[k].delete();
        if (nsw == 0) begin
            cur_m[k] = mk(0, 1, 1, 1, 0);
            q_m[k].push_back(mk(0, 1, 0, 0, 0));
            return;
        end
        held = mk(0, 1, 1, 0, 0);
        cur_m[k] = held;
        for (int s = 1; s <= nsw; s++) begin
            for (int i = 1; i <= 2 * (n - 1); i++) begin
                nxt = held;
                if (i <= n - 1) begin
                    v = i;
                    nxt.updown = (v == n - 1) ? 1'b0 : 1'b1;
                end else begin
                    v = 2 * (n - 1) - i;
                    nxt.updown = (v == 0) ? 1'b1 : 1'b0;
                    if (v == 0) begin
                        nxt.sw   = 8'(s);
                        nxt.done = (s == nsw);
                    end
                end
                nxt.count = 4'(v);
                for (int d = 0; d < dw; d++) q_m[k].push_back(held);
                q_m[k].push_back(nxt);
                held = nxt;
            end
        end
        q_m[k].push_back(mk(0, 1, 0, 0, nsw));
    endtask

    task automatic model_step(input int k, input int n);
        if (!reset) begin
            q_m[k].delete();
            cur_m[k] = mk(0, 1, 0, 0, 0);
        end else if (q_m[k].size() != 0) begin
            if (abort && !cur_m[k].done) begin
                q_m[k].delete();
                cur_m[k].busy   = 1'b0;
                cur_m[k].updown = 1'b1;
            end else begin
                cur_m[k] = q_m[k].pop_front();
            end
        end else if (start && !abort) begin
            build_run(k, n, int'(sweeps), int'(dwell));
        end
    endtask

    always @(posedge clk) begin
        model_step(0, NA);
        model_step(1, NB);
        mvalid = 1'b1;
    end

    always @(negedge clk) begin
        if (mvalid) begin
            check("a.count",  32'(count_a),  32'(cur_m[0].count));
            check("a.updown", 32'(updown_a), 32'(cur_m[0].updown));
            check("a.busy",   32'(busy_a),   32'(cur_m[0].busy));
            check("a.done",   32'(done_a),   32'(cur_m[0].done));
            check("a.swcnt",  32'(swc_a),    32'(cur_m[0].sw));
            check("b.count",  32'(count_b),  32'(cur_m[1].count));
            check("b.updown", 32'(updown_b), 32'(cur_m[1].updown));
            check("b.busy",   32'(busy_b),   32'(cur_m[1].busy));
            check("b.done",   32'(done_b),   32'(cur_m[1].done));
            check("b.swcnt",  32'(swc_b),    32'(cur_m[1].sw));
        end
    end

    task automatic pulse_start(input int nsw, input int dw);
        sweeps = SW'(nsw);
        dwell  = 4'(dw);
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
    endtask

    initial begin
        int seq_b [6];
        int n;
        seq_b = '{1, 2, 3, 2, 1, 0};

        // Power-on reset
        repeat (3) @(negedge clk);
        check("rst.count", 32'(count_a), 0);
        check("rst.updown", 32'(updown_a), 1);
        check("rst.busy", 32'(busy_a), 0);
        check("rst.swcnt", 32'(swc_a), 0);
        reset = 1'b1;
        @(negedge clk);

        $display("txn: single sweep, dwell=0");
        pulse_start(1, 0);
        check("n4.first.count", 32'(count_b), 0);
        check("n4.first.busy", 32'(busy_b), 1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("n4.seq.count", 32'(count_b), 32'(seq_b[i]));
            check("n4.seq.done", 32'(done_b), (i == 5) ? 32'd1 : 32'd0);
            if (i == 2) check("n4.updown_fall", 32'(updown_b), 0);
            if (i == 1) check("n4.updown_rise", 32'(updown_b), 1);
        end
        @(negedge clk);
        check("n4.busy_after", 32'(busy_b), 0);
        check("n4.done_after", 32'(done_b), 0);
        repeat (14) @(negedge clk);

        $display("txn: three sweeps, dwell=2, with start while busy");
        pulse_start(3, 2);
        n = 0;
        while (!done_a && n < 400) begin
            if (n == 50) begin
                sweeps = 8'd1;
                dwell  = 4'd0;
                start  = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        check("n10.run_len", 32'(n), 162);
        check("n10.final_swcnt", 32'(swc_a), 3);
        @(negedge clk);
        check("n10.busy_after", 32'(busy_a), 0);

        $display("txn: abort in DOWN at count 5");
        pulse_start(2, 0);
        repeat (13) @(negedge clk);
        check("abort.pre.count", 32'(count_a), 5);
        check("abort.pre.updown", 32'(updown_a), 0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort.busy", 32'(busy_a), 0);
        check("abort.count", 32'(count_a), 5);
        check("abort.swcnt", 32'(swc_a), 0);
        repeat (3) begin
            @(negedge clk);
            check("abort.hold.count", 32'(count_a), 5);
            check("abort.hold.done", 32'(done_a), 0);
        end

        $display("txn: start and abort together in IDLE");
        sweeps = 8'd1;
        start  = 1'b1;
        abort  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("sa.busy", 32'(busy_a), 0);
        check("sa.count", 32'(count_a), 5);

        $display("txn: restart after abort");
        pulse_start(1, 0);
        check("restart.count", 32'(count_a), 0);
        check("restart.busy", 32'(busy_a), 1);
        repeat (25) @(negedge clk);

        $display("txn: zero sweeps");
        pulse_start(0, 3);
        check("zero.done", 32'(done_a), 1);
        check("zero.busy", 32'(busy_a), 1);
        check("zero.count", 32'(count_a), 0);
        @(negedge clk);
        check("zero.busy_after", 32'(busy_a), 0);
        check("zero.done_after", 32'(done_a), 0);

        $display("txn: reset mid-run");
        pulse_start(2, 1);
        repeat (7) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("mrst.count", 32'(count_a), 0);
        check("mrst.updown", 32'(updown_a), 1);
        check("mrst.busy", 32'(busy_a), 0);
        check("mrst.done", 32'(done_a), 0);
        check("mrst.swcnt", 32'(swc_a), 0);
        reset = 1'b1;
        @(negedge clk);

        $display("txn: randomized phase, 3000 cycles");
        for (int c = 0; c < 3000; c++) begin
            reset  = ($urandom_range(0, 299) != 0);
            start  = ($urandom_range(0, 7) == 0);
            abort  = ($urandom_range(0, 59) == 0);
            sweeps = SW'($urandom_range(0, 3));
            dwell  = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
            @(negedge clk);
        end
        reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
